// File: rtl/ddr_bus_pkg.sv
// rtl/ddr_bus_pkg.sv - shared types and default widths for the DDR channel responder
package ddr_bus_pkg;

    // Refresh controller state: RUN accepts requests, REFRESH stalls them.
    typedef enum logic {
        RUN     = 1'b0,
        REFRESH = 1'b1
    } ref_state_t;

    localparam int DEF_ADDR_W     = 14;
    localparam int DEF_OFFCHIP_DW = 512;

endpackage

// File: rtl/ddr_rd_pipe.sv
// rtl/ddr_rd_pipe.sv - fixed-latency valid+data shift register for read returns
//
// Ports:
//   clk, rst (async active-low), ce (0 freezes every stage)
//   in_valid/in_data   : word sampled from the array at the accepting edge
//   out_valid/out_data : last stage; out_data keeps the last returned word
module ddr_rd_pipe #(
    parameter int DW  = 512,
    parameter int LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic [LAT-1:0] vld;
    logic [DW-1:0]  dat [LAT];

    // Data only advances together with a valid token, so each stage (and in
    // particular the output stage) keeps the last word that passed through it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                dat[i] <= '0;
            end
        end else if (ce) begin
            vld[0] <= in_valid;
            if (in_valid) begin
                dat[0] <= in_data;
            end
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign out_valid = vld[LAT-1];
    assign out_data  = dat[LAT-1];

endmodule

// File: rtl/ddr_bus_responder.sv
// rtl/ddr_bus_responder.sv - off-chip DDR channel responder with fixed read latency and refresh stalls
//
// Ports:
//   clk, rst (async active-low), ce (0 freezes all state)
//   r_valid/r_addr/r_ready          : read request handshake
//   w_valid/w_addr/w_data/w_ready   : write request handshake
//   rdata/rdata_valid               : read return, RD_LAT cycles after acceptance
//   busy_refresh                    : high while the channel is refreshing
module ddr_bus_responder
    import ddr_bus_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int OFFCHIP_DW = DEF_OFFCHIP_DW,
    parameter int MEM_AW     = 10,
    parameter int RD_LAT     = 4,
    parameter int REF_PERIOD = 64,
    parameter int REF_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  r_valid,
    input  logic [ADDR_W-1:0]     r_addr,
    output logic                  r_ready,
    input  logic                  w_valid,
    input  logic [ADDR_W-1:0]     w_addr,
    input  logic [OFFCHIP_DW-1:0] w_data,
    output logic                  w_ready,
    output logic [OFFCHIP_DW-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  busy_refresh
);

    localparam int CNT_W = $clog2(REF_PERIOD);

    ref_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic [OFFCHIP_DW-1:0] mem [2**MEM_AW];

    logic [MEM_AW-1:0]     r_idx, w_idx;
    logic                  r_fire, w_fire;
    logic [OFFCHIP_DW-1:0] rd_word;

    // Upper address bits are intentionally dropped: the address space wraps.
    logic unused_upper_addr;
    assign unused_upper_addr = ^{r_addr[ADDR_W-1:MEM_AW], w_addr[ADDR_W-1:MEM_AW]};

    assign r_idx = r_addr[MEM_AW-1:0];
    assign w_idx = w_addr[MEM_AW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else if (ce) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The refresh decision is taken on the edge where the run counter would
    // reach REF_PERIOD-1, so a run phase is REF_PERIOD-1 cycles long and the
    // first stall from reset appears in cycle REF_PERIOD-1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        case (state)
            RUN: begin
                if (cnt == CNT_W'(REF_PERIOD - 2)) begin
                    state_nxt = REFRESH;
                    cnt_nxt   = '0;
                end
            end
            REFRESH: begin
                if (cnt == CNT_W'(REF_LEN - 1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Ready is decoded from the state register only, never from valid.
    assign r_ready      = (state == RUN);
    assign w_ready      = (state == RUN);
    assign busy_refresh = (state == REFRESH);

    assign r_fire = ce && r_valid && r_ready;
    assign w_fire = ce && w_valid && w_ready;

    always_ff @(posedge clk) begin
        if (w_fire) begin
            mem[w_idx] <= w_data;
        end
    end

    // Write-first: a read colliding with a same-edge write returns the new data.
    assign rd_word = (w_fire && (w_idx == r_idx)) ? w_data : mem[r_idx];

    ddr_rd_pipe #(
        .DW  (OFFCHIP_DW),
        .LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (r_fire),
        .in_data   (rd_word),
        .out_valid (rdata_valid),
        .out_data  (rdata)
    );

endmodule

// File: tb/tb_ddr_bus_responder.sv
// tb/tb_ddr_bus_responder.sv - self-checking bench for ddr_bus_responder
module tb_ddr_bus_responder;

    localparam int ADDR_W     = 14;
    localparam int DW         = 512;
    localparam int MEM_AW     = 10;
    localparam int RD_LAT     = 4;
    localparam int REF_PERIOD = 64;
    localparam int REF_LEN    = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ce = 1'b1;
    logic              r_valid = 1'b0;
    logic [ADDR_W-1:0] r_addr = '0;
    logic              r_ready;
    logic              w_valid = 1'b0;
    logic [ADDR_W-1:0] w_addr = '0;
    logic [DW-1:0]     w_data = '0;
    logic              w_ready;
    logic [DW-1:0]     rdata;
    logic              rdata_valid;
    logic              busy_refresh;

    always #5 clk = ~clk;

    ddr_bus_responder #(
        .ADDR_W     (ADDR_W),
        .OFFCHIP_DW (DW),
        .MEM_AW     (MEM_AW),
        .RD_LAT     (RD_LAT),
        .REF_PERIOD (REF_PERIOD),
        .REF_LEN    (REF_LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .r_valid      (r_valid),
        .r_addr       (r_addr),
        .r_ready      (r_ready),
        .w_valid      (w_valid),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .w_ready      (w_ready),
        .rdata        (rdata),
        .rdata_valid  (rdata_valid),
        .busy_refresh (busy_refresh)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: time is counted in enabled cycles since reset; the
    // refresh window is a fixed slice of a (REF_PERIOD-1)+REF_LEN cycle frame.
    typedef struct {
        int            due;
        logic [DW-1:0] data;
        bit            known;
    } ret_t;

    ret_t          q[$];
    int            n = 0;
    logic [DW-1:0] mem_m [2**MEM_AW];
    bit            known_m [2**MEM_AW];
    logic [DW-1:0] last_ret = '0;
    bit            last_known = 1'b1;

    function automatic bit in_ref(input int c);
        return (c % (REF_PERIOD - 1 + REF_LEN)) >= (REF_PERIOD - 1);
    endfunction

    always @(posedge clk or negedge rst) begin
        ret_t e;
        if (!rst) begin
            q.delete();
            n          = 0;
            last_ret   = '0;
            last_known = 1'b1;
        end else if (ce) begin
            if (q.size() > 0 && q[0].due == n) begin
                last_ret   = q[0].data;
                last_known = q[0].known;
                void'(q.pop_front());
            end
            if (!in_ref(n)) begin
                if (w_valid) begin
                    mem_m[w_addr[MEM_AW-1:0]]   = w_data;
                    known_m[w_addr[MEM_AW-1:0]] = 1'b1;
                end
                if (r_valid) begin
                    e.due   = n + RD_LAT;
                    e.data  = mem_m[r_addr[MEM_AW-1:0]];
                    e.known = known_m[r_addr[MEM_AW-1:0]];
                    q.push_back(e);
                end
            end
            n++;
        end
    end

    always @(negedge clk) begin
        bit ev;
        ev = (q.size() > 0) && (q[0].due == n);
        chk("m_r_ready", r_ready, !in_ref(n));
        chk("m_w_ready", w_ready, !in_ref(n));
        chk("m_busy_refresh", busy_refresh, in_ref(n));
        chk("m_rdata_valid", rdata_valid, ev);
        if (ev) begin
            if (q[0].known) chk("m_rdata", rdata, q[0].data);
        end else if (last_known) begin
            chk("m_rdata_hold", rdata, last_ret);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b0; r_valid = 1'b0; w_valid = 1'b0; ce = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic wait_ret(input int start, output int lat);
        lat = start;
        while (!rdata_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, output int lat);
        r_valid = 1'b1; r_addr = a;
        step();
        r_valid = 1'b0;
        wait_ret(1, lat);
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        return {a[3:0], 10'(16 + int'(a[6:4]))};
    endfunction

    bit rr [0:71];
    bit bz [0:71];
    bit vv [0:71];

    initial begin
        int lat;
        int cnt;
        bit r_acc, w_acc;

        // Reset values, simple write then read, wrap, write-first.
        do_reset();
        chk("rst_r_ready", r_ready, 1'b1);
        chk("rst_rdata_valid", rdata_valid, 1'b0);
        chk("rst_rdata", rdata, '0);
        chk("rst_busy", busy_refresh, 1'b0);

        w_valid = 1'b1; w_addr = 14'd5; w_data = {64{8'hA5}};
        step();
        w_valid = 1'b0;
        rd(14'd5, lat);
        chk("a5_lat", lat, 4);
        chk("a5_data", rdata, {64{8'hA5}});
        step();
        chk("a5_single_pulse", rdata_valid, 1'b0);
        chk("a5_hold", rdata, {64{8'hA5}});

        w_valid = 1'b1; w_addr = 14'd7; w_data = {64{8'h11}};
        r_valid = 1'b1; r_addr = 14'd7;
        step();
        w_valid = 1'b0; r_valid = 1'b0;
        wait_ret(1, lat);
        chk("wf_lat", lat, 4);
        chk("wf_data", rdata, {64{8'h11}});

        r_valid = 1'b1; r_addr = 14'd7;
        step();
        r_valid = 1'b0;
        w_valid = 1'b1; w_addr = 14'd7; w_data = {64{8'h22}};
        step();
        w_valid = 1'b0;
        wait_ret(2, lat);
        chk("war_lat", lat, 4);
        chk("war_data", rdata, {64{8'h11}});
        rd(14'd7, lat);
        chk("war_new_data", rdata, {64{8'h22}});

        rd(14'h0405, lat);
        chk("wrap_rd_data", rdata, {64{8'hA5}});
        w_valid = 1'b1; w_addr = 14'h2C09; w_data = {64{8'h33}};
        step();
        w_valid = 1'b0;
        rd(14'd9, lat);
        chk("wrap_wr_data", rdata, {64{8'h33}});

        // Refresh window with r_valid held from reset.
        do_reset();
        r_valid = 1'b1; r_addr = 14'd5;
        for (int k = 0; k < 72; k++) begin
            rr[k] = r_ready; bz[k] = busy_refresh; vv[k] = rdata_valid;
            step();
        end
        r_valid = 1'b0;
        chk("ref_ready_62", rr[62], 1'b1);
        chk("ref_ready_63", rr[63], 1'b0);
        chk("ref_ready_66", rr[66], 1'b0);
        chk("ref_ready_67", rr[67], 1'b1);
        chk("ref_busy_62", bz[62], 1'b0);
        chk("ref_busy_63", bz[63], 1'b1);
        chk("ref_busy_66", bz[66], 1'b1);
        chk("ref_busy_67", bz[67], 1'b0);
        chk("ref_drain_66", vv[66], 1'b1);
        chk("ref_gap_67", vv[67], 1'b0);
        chk("ref_gap_70", vv[70], 1'b0);
        chk("ref_resume_71", vv[71], 1'b1);

        // Asynchronous reset with reads in flight.
        do_reset();
        r_valid = 1'b1; r_addr = 14'd5;
        repeat (5) step();
        r_valid = 1'b0;
        chk("pre_rst_valid", rdata_valid, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valid", rdata_valid, 1'b0);
        chk("async_rst_rdata", rdata, '0);
        repeat (2) step();
        rst = 1'b1;
        cnt = 0;
        repeat (8) begin
            step();
            cnt += int'(rdata_valid);
        end
        chk("no_ret_after_rst", cnt, 0);

        // Clock-enable freeze delays both the return and the refresh.
        do_reset();
        r_valid = 1'b1; r_addr = 14'd7;
        step();
        r_valid = 1'b0;
        lat = 1;
        ce = 1'b0;
        repeat (10) begin
            step();
            lat++;
        end
        ce = 1'b1;
        wait_ret(lat, lat);
        chk("ce_lat", lat, 14);
        chk("ce_data", rdata, {64{8'h22}});
        while (r_ready && cyc < 300) step();
        chk("ce_ref_shift", cyc, 73);

        // Randomized traffic against the model; requests hold until accepted.
        do_reset();
        r_acc = 1'b0; w_acc = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            ce = ($urandom_range(9) != 0);
            if (!r_valid || r_acc) begin
                r_valid = $urandom_range(1);
                r_addr  = rand_addr();
            end
            if (!w_valid || w_acc) begin
                w_valid = $urandom_range(1);
                w_addr  = rand_addr();
                w_data  = rand_word();
            end
            r_acc = r_valid && r_ready && ce;
            w_acc = w_valid && w_ready && ce;
            step();
        end
        r_valid = 1'b0; w_valid = 1'b0; ce = 1'b1;
        repeat (RD_LAT + 2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
